div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 4, meaning the number of settle cycles allowed for the combinational divider (legal range 1..15).
REQ-002 SHALL have port clk_i  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_valid_i  input  1  divide request valid.
REQ-005 SHALL have port req_ready_o  output  1  unit can accept a request.
REQ-006 SHALL have port req_op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-007 SHALL have port req_a_i  input  32  dividend (rs1).
REQ-008 SHALL have port req_b_i  input  32  divisor (rs2).
REQ-009 SHALL have port req_tag_i  input  5  destination register tag.
REQ-010 SHALL have port flush_i  input  1  pipeline kill; discards the in-flight operation.
REQ-011 SHALL have port rsp_valid_o  output  1  result valid.
REQ-012 SHALL have port rsp_ready_i  input  1  consumer accepts result.
REQ-013 SHALL have port rsp_data_o  output  32  quotient or remainder per op.
REQ-014 SHALL have port rsp_tag_o  output  5  tag of the request that produced rsp_data_o.
REQ-015 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 SHALL assert req_ready_o only in IDLE with flush_i low; acceptance = req_valid_i & req_ready_o.
REQ-018 SHALL register op, tag and divider operands on acceptance; divider inputs stay constant until the next acceptance.
REQ-019 Signed ops (DIV, REM): SHALL feed divider with two's-complement magnitudes; negate quotient when operand signs differ; give remainder the dividend's sign.
REQ-020 Divisor zero: SHALL skip BUSY, go IDLE->DONE; result quotient 0xFFFFFFFF (all ops), remainder = dividend unmodified.
REQ-021 Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): SHALL skip BUSY; quotient 0x80000000, remainder 0.
REQ-022 Normal case: IDLE->BUSY on acceptance; BUSY counts DIV_CYCLES cycles; then BUSY->DONE with result registered from divider output.
REQ-023 Latency: rsp_valid_o SHALL rise DIV_CYCLES+1 cycles after acceptance edge (normal) or 1 cycle after (special cases).
REQ-024 DONE: rsp_valid_o high; rsp_data_o/rsp_tag_o stable while rsp_ready_i low; DONE->IDLE when rsp_ready_i high.
REQ-025 No back-to-back acceptance in the DONE-exit cycle; next request accepted earliest the cycle after return to IDLE.
REQ-026 flush_i in BUSY or DONE SHALL force IDLE next cycle, rsp_valid_o low, no response emitted; flush_i has priority over rsp_ready_i and counter expiry.
REQ-027 flush_i in IDLE with req_valid_i high SHALL NOT accept the request.

Reset
REQ-028 rst_ni low SHALL immediately force IDLE, counter 0, rsp_valid_o 0, rsp_data_o 0, rsp_tag_o 0, busy_o 0, req_ready_o 0 while held low.
REQ-029 Reset mid-operation SHALL discard the operation; no response after release.
REQ-030 req_ready_o SHALL be 1 in the first cycle after reset release if flush_i low.

Structure
REQ-031 Shared package div_pkg SHALL hold the op encoding enum, FSM state enum, and constants for the divide-by-zero quotient (0xFFFFFFFF) and INT_MIN (0x80000000).
REQ-032 SHALL instantiate one sub-module, non_restoring_div (ports src1, src2, qut, rmd), as the unsigned datapath; sign fix-up and special cases live in div_seq.

Verification
REQ-033 DIVU a=1000 b=33, rsp_ready_i=1 -> rsp_data_o=30 at acceptance+5 cycles (DIV_CYCLES=4); REMU same -> 10.
REQ-034 DIV a=-7 (0xFFFFFFF9) b=2 -> 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); REM a=7 b=-2 -> 1.
REQ-035 DIVU a=5 b=0 -> 0xFFFFFFFF at acceptance+1; REMU -> 5; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-036 DIVU a=0xFFFFFFFF b=2, rsp_ready_i low 3 cycles in DONE -> rsp_data_o holds 0x7FFFFFFF, tag held, req_ready_o low until exit.
REQ-037 flush_i pulsed 2 cycles into BUSY -> no rsp_valid_o, IDLE next cycle, following DIVU 100/1 -> 100 with its own tag.
REQ-038 rst_ni dropped in BUSY -> outputs zero immediately; after release no response for the aborted op.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RISC-V divide unit.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    function automatic logic op_is_signed(div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/non_restoring_div.sv
// Unsigned 32-bit combinational non-restoring divider; result settles over several cycles.
module non_restoring_div (
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] qut,
    output logic [31:0] rmd
);

    // A 34-bit partial remainder keeps 2*r + bit representable when r is close to the divisor.
    logic [33:0] part;
    logic [31:0] quot;

    always_comb begin
        part = '0;
        quot = '0;
        for (int i = 31; i >= 0; i--) begin
            if (!part[33]) begin
                part = {part[32:0], src1[i]} - {2'b00, src2};
            end else begin
                part = {part[32:0], src1[i]} + {2'b00, src2};
            end
            quot[i] = ~part[33];
        end
        if (part[33]) begin
            part = part + {2'b00, src2};
        end
        qut = quot;
        rmd = part[31:0];
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle divide unit: registers operands, waits DIV_CYCLES for the divider to settle,
// then holds the signed/unsigned quotient or remainder until the consumer takes it.
module div_seq #(
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic [4:0]  req_tag_i,
    input  logic        flush_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic [4:0]  rsp_tag_o,
    output logic        busy_o
);
    import div_pkg::*;

    div_state_e  state_q, state_d;
    div_op_e     op_q;
    logic [3:0]  cnt_q;
    logic [4:0]  tag_q, rsp_tag_q;
    logic [31:0] src1_q, src2_q, qut, rmd, rsp_data_q;
    logic        neg_quot_q, neg_rem_q;
    logic        accept, req_signed, a_neg, b_neg, div_zero, overflow, special;
    logic        cnt_last, load_div;
    logic [31:0] special_result, div_result;

    assign accept     = req_valid_i & req_ready_o;
    assign req_signed = op_is_signed(div_op_e'(req_op_i));
    assign a_neg      = req_signed & req_a_i[31];
    assign b_neg      = req_signed & req_b_i[31];
    assign div_zero   = (req_b_i == '0);
    assign overflow   = req_signed && (req_a_i == INT_MIN) && (req_b_i == 32'hFFFF_FFFF);
    assign special    = div_zero | overflow;
    assign cnt_last   = (cnt_q == 4'(DIV_CYCLES - 1));
    assign load_div   = (state_q == ST_BUSY) && !flush_i && cnt_last;

    // Special cases bypass the divider, so their result is known at acceptance.
    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = req_op_i[1] ? req_a_i : DIV_ZERO_QUOT;
        end else if (overflow) begin
            special_result = req_op_i[1] ? 32'h0 : INT_MIN;
        end
    end

    assign div_result = op_is_rem(op_q) ? (neg_rem_q  ? -rmd : rmd)
                                        : (neg_quot_q ? -qut : qut);

    non_restoring_div u_div (
        .src1 (src1_q),
        .src2 (src2_q),
        .qut  (qut),
        .rmd  (rmd)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush outranks both counter expiry and response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)                state_d = special ? ST_DONE : ST_BUSY;
            ST_BUSY: if (flush_i)               state_d = ST_IDLE;
                     else if (cnt_last)         state_d = ST_DONE;
            ST_DONE: if (flush_i || rsp_ready_i) state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = rst_ni && (state_q == ST_IDLE) && !flush_i;
        busy_o      = (state_q != ST_IDLE);
        rsp_valid_o = (state_q == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if ((state_q == ST_BUSY) && (state_d == ST_BUSY)) begin
            cnt_q <= cnt_q + 4'd1;
        end else begin
            cnt_q <= '0;
        end
    end

    // Divider operands are magnitudes; sign fix-up is applied when the result is captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= OP_DIV;
            tag_q      <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
        end else begin
            if (accept) begin
                op_q       <= div_op_e'(req_op_i);
                tag_q      <= req_tag_i;
                src1_q     <= a_neg ? -req_a_i : req_a_i;
                src2_q     <= b_neg ? -req_b_i : req_b_i;
                neg_quot_q <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
            end
            if (accept && special) begin
                rsp_data_q <= special_result;
                rsp_tag_q  <= req_tag_i;
            end else if (load_div) begin
                rsp_data_q <= div_result;
                rsp_tag_q  <= tag_q;
            end
        end
    end

    assign rsp_data_o = rsp_data_q;
    assign rsp_tag_o  = rsp_tag_q;

endmodule
